// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous single-port memory.
// Port B can lock out port A; an idle watchdog force-releases a stale lock.
module mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              b_lock,
  output logic              core_halt,
  output logic              lock_timeout,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t          state_q, state_d;
  logic            last_b_q, last_b_d;
  logic [CW-1:0]   idle_q, idle_d;
  logic            a_pend_q, a_pend_d;
  logic            b_pend_q, b_pend_d;
  logic            relock_blk_q, relock_blk_d;
  logic            to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNLOCKED;
      last_b_q     <= 1'b1;
      idle_q       <= '0;
      a_pend_q     <= 1'b0;
      b_pend_q     <= 1'b0;
      relock_blk_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_b_q     <= last_b_d;
      idle_q       <= idle_d;
      a_pend_q     <= a_pend_d;
      b_pend_q     <= b_pend_d;
      relock_blk_q <= relock_blk_d;
    end
  end

  // After a forced release the block holds until b_lock is seen low.
  always_comb begin
    state_d      = state_q;
    last_b_d     = last_b_q;
    idle_d       = idle_q;
    relock_blk_d = relock_blk_q & b_lock;
    a_pend_d     = a_gnt & ~a_we;
    b_pend_d     = b_gnt & ~b_we;
    if (a_gnt | b_gnt) last_b_d = b_gnt;
    case (state_q)
      UNLOCKED: begin
        idle_d = '0;
        if (b_gnt && b_lock && !relock_blk_q) state_d = LOCKED;
      end
      LOCKED: begin
        if (!b_lock) begin
          state_d = UNLOCKED;
          idle_d  = '0;
        end else if (to_hit) begin
          state_d      = UNLOCKED;
          idle_d       = '0;
          relock_blk_d = 1'b1;
        end else if (b_req) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Grants are qualified by rst_n so reset silences the memory port at once.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == LOCKED) begin
        b_gnt = b_req;
      end else if (a_req && b_req) begin
        a_gnt = last_b_q;
        b_gnt = ~last_b_q;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
    mem_en       = a_gnt | b_gnt;
    mem_we       = (a_gnt & a_we) | (b_gnt & b_we);
    mem_addr     = a_gnt ? a_addr  : (b_gnt ? b_addr  : '0);
    mem_wdata    = a_gnt ? a_wdata : (b_gnt ? b_wdata : '0);
    a_rvalid     = a_pend_q;
    b_rvalid     = b_pend_q;
    a_rdata      = a_pend_q ? mem_rdata : '0;
    b_rdata      = b_pend_q ? mem_rdata : '0;
    core_halt    = (state_q == LOCKED);
    to_hit       = (state_q == LOCKED) && b_lock && !b_req && (idle_q == IDLE_LAST);
    lock_timeout = to_hit;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle model predicts grants and
// memory-port values; predicted read data is queued and checked on rvalid.
module tb_mem_arbiter;
  localparam int LT = 4;

  logic        clk, rst_n;
  logic        a_req, a_we, b_req, b_we, b_lock;
  logic [7:0]  a_addr, b_addr, mem_addr;
  logic [15:0] a_wdata, b_wdata, mem_wdata, mem_rdata, a_rdata, b_rdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, core_halt, lock_timeout, mem_en, mem_we;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .b_lock(b_lock), .core_halt(core_halt), .lock_timeout(lock_timeout),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory behind the arbiter
  logic [15:0] tmem [256];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) tmem[mem_addr] <= mem_wdata;
      else        mem_rdata      <= tmem[mem_addr];
    end

  typedef struct { int cyc; logic [15:0] data; } exp_t;
  exp_t qa[$], qb[$];
  int tests = 0, fails = 0, cyc = 0;
  logic [15:0] ref_mem [256];
  bit m_locked, m_last_b, m_block, a_hold, b_hold;
  int m_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_last_b = 1; m_block = 0; m_idle = 0;
    a_hold = 0; b_hold = 0;
    qa.delete(); qb.delete();
  endtask

  // Reference: arbitration rules applied to current inputs, then advance.
  task automatic check_cycle();
    logic ea, eb, eto;
    ea = 0; eb = 0;
    if (m_locked) eb = b_req;
    else if (a_req && b_req) begin ea = m_last_b; eb = !m_last_b; end
    else begin ea = a_req; eb = b_req; end
    eto = m_locked && b_lock && !b_req && (m_idle == LT - 1);
    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    chk("core_halt", core_halt, m_locked);
    chk("lock_timeout", lock_timeout, eto);
    chk("mem_en", mem_en, ea | eb);
    chk("mem_we", mem_we, (ea & a_we) | (eb & b_we));
    chk("mem_addr", mem_addr, ea ? a_addr : (eb ? b_addr : 8'h0));
    chk("mem_wdata", mem_wdata, ea ? a_wdata : (eb ? b_wdata : 16'h0));
    if (ea) begin
      if (a_we) ref_mem[a_addr] = a_wdata;
      else qa.push_back('{cyc, ref_mem[a_addr]});
    end
    if (eb) begin
      if (b_we) ref_mem[b_addr] = b_wdata;
      else qb.push_back('{cyc, ref_mem[b_addr]});
    end
    if (ea || eb) m_last_b = eb;
    if (m_locked) begin
      if (!b_lock) begin m_locked = 0; m_idle = 0; end
      else if (eto) begin m_locked = 0; m_idle = 0; m_block = 1; end
      else m_idle = b_req ? 0 : m_idle + 1;
    end else if (eb && b_lock && !m_block) begin
      m_locked = 1; m_idle = 0;
    end
    if (!b_lock) m_block = 0;
    a_hold = a_req && !ea;
    b_hold = b_req && !eb;
  endtask

  task automatic step();
    #1 check_cycle();
    @(negedge clk);
  endtask

  task automatic drive(input logic ar, aw, input logic [7:0] aa, input logic [15:0] ad,
                       input logic br, bw, input logic [7:0] ba, input logic [15:0] bd,
                       input logic bl);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
  endtask

  // Monitor: read responses appear exactly one cycle after the grant.
  always @(posedge clk) begin
    logic ev;
    cyc++;
    #1;
    while (qa.size() > 0 && qa[0].cyc < cyc - 1) void'(qa.pop_front());
    while (qb.size() > 0 && qb[0].cyc < cyc - 1) void'(qb.pop_front());
    ev = qa.size() > 0 && qa[0].cyc == cyc - 1;
    chk("a_rvalid", a_rvalid, ev);
    if (ev) chk("a_rdata", a_rdata, qa.pop_front().data);
    else    chk("a_rdata_idle", a_rdata, 16'h0);
    ev = qb.size() > 0 && qb[0].cyc == cyc - 1;
    chk("b_rvalid", b_rvalid, ev);
    if (ev) chk("b_rdata", b_rdata, qb.pop_front().data);
    else    chk("b_rdata_idle", b_rdata, 16'h0);
  end

  initial begin
    foreach (tmem[i]) begin tmem[i] = 16'h0; ref_mem[i] = 16'h0; end
    mem_rdata = 16'h0;
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_core_halt", core_halt, 0);
    chk("rst_gnt", {a_gnt, b_gnt}, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("rst_lock_timeout", lock_timeout, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // tie after reset alternates A,B,A,B
    repeat (4) begin drive(1, 0, 8'h01, 0, 1, 0, 8'h02, 0, 0); step(); end
    // B write, then A read-back
    drive(0, 0, 0, 0, 1, 1, 8'h05, 16'h1234, 0); step();
    drive(1, 0, 8'h05, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0, 8'h05, 0, 0); step();
    // A wins with b_lock up, B gets next grant and locks
    drive(1, 0, 8'h05, 0, 1, 0, 8'h06, 0, 1); step();
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 8'h05, 0, 1'($urandom), 0, 8'h05, 0, 1);
      #1;
      chk("lock_a_gnt", a_gnt, 0);
      chk("lock_halt", core_halt, 1);
      step();
    end
    drive(1, 0, 8'h05, 0, 0, 0, 0, 0, 0); step();
    #1 chk("unlock_a_gnt", a_gnt, 1);
    step();
    // lock, idle to timeout, no re-lock until b_lock drops
    drive(0, 0, 0, 0, 1, 0, 8'h07, 0, 1); step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1 chk("timeout_pulse", lock_timeout, i == 3);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, 8'h07, 0, 1);
      #1 chk("no_relock", core_halt, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0, 8'h05, 0, 1); step();
    #1 chk("relock", core_halt, 1);
    // reset mid-cycle while locked with reads in flight
    drive(1, 0, 8'h05, 0, 1, 0, 8'h05, 0, 1); step();
    #1 check_cycle();
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_halt", core_halt, 0);
    chk("midrst_rvalid", {a_rvalid, b_rvalid}, 0);
    chk("midrst_mem_en", mem_en, 0);
    chk("midrst_timeout", lock_timeout, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); end

    // randomized traffic; ungranted requests are held
    b_lock = 0;
    for (int n = 0; n < 800; n++) begin
      if (!a_hold) begin
        a_req = ($urandom % 3) != 0; a_we = 1'($urandom);
        a_addr = 8'($urandom % 16); a_wdata = 16'($urandom);
      end
      if (!b_hold) begin
        b_req = 1'($urandom); b_we = 1'($urandom);
        b_addr = 8'($urandom % 16); b_wdata = 16'($urandom);
      end
      if ($urandom % 6 == 0) b_lock = !b_lock;
      step();
    end
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the memory word-address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the memory data width.
REQ-003 Parameter LOCK_TIMEOUT, default 64, SHALL set the idle-cycle limit on a port-B lock.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 a_req  in  1  SHALL be the core-side (port A) access request.
REQ-007 a_we  in  1  SHALL select port A write (1) or read (0).
REQ-008 a_addr  in  ADDR_W  SHALL be the port A word address.
REQ-009 a_wdata  in  DATA_W  SHALL be the port A write data.
REQ-010 a_gnt  out  1  SHALL indicate that port A's access is issued this cycle.
REQ-011 a_rvalid  out  1  SHALL indicate that a_rdata holds port A read data.
REQ-012 a_rdata  out  DATA_W  SHALL be the port A read data.
REQ-013 b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata SHALL mirror the port A signals for the loader/debug port (port B).
REQ-014 b_lock  in  1  SHALL request exclusive ownership by port B.
REQ-015 core_halt  out  1  SHALL be 1 while port B holds the lock.
REQ-016 lock_timeout  out  1  SHALL be a one-cycle pulse when a lock is force-released.
REQ-017 mem_en, mem_we  out  1  SHALL drive the synchronous single-port memory access enable and write enable.
REQ-018 mem_addr  out  ADDR_W  and  mem_wdata  out  DATA_W  SHALL carry the granted port's address and write data.
REQ-019 mem_rdata  in  DATA_W  SHALL be the memory read data, valid one cycle after the read is issued.

Function
REQ-020 Grant decision SHALL be combinational from the requests and registered state; at most one of a_gnt and b_gnt SHALL be 1 per cycle.
REQ-021 Exactly one requester, state UNLOCKED: that requester SHALL be granted in the same cycle.
REQ-022 Both requesting, state UNLOCKED: the port not granted most recently SHALL win; the last-grant pointer updates only on a grant.
REQ-023 mem_en SHALL equal a_gnt|b_gnt; mem_we SHALL be mem_en & the granted port's we; mem_addr/mem_wdata SHALL be taken from the granted port; when no grant, mem_addr and mem_wdata SHALL be 0.
REQ-024 A granted read SHALL produce rvalid=1 on that port exactly one cycle later, with rdata = mem_rdata; writes SHALL produce no rvalid.
REQ-025 rdata of a port SHALL be 0 when its rvalid is 0.
REQ-026 Lock FSM states: UNLOCKED and LOCKED.
REQ-027 UNLOCKED->LOCKED SHALL occur at the edge ending a cycle with b_gnt=1 and b_lock=1.
REQ-028 In LOCKED: a_gnt SHALL be 0; b_req SHALL be granted every cycle it is asserted; core_halt SHALL be 1.
REQ-029 LOCKED->UNLOCKED SHALL occur at the edge that samples b_lock=0; port A is then eligible in the next cycle.
REQ-030 An idle counter SHALL count LOCKED cycles with b_req=0, clear on b_req=1 or on leaving LOCKED, and on reaching LOCK_TIMEOUT force LOCKED->UNLOCKED and pulse lock_timeout for one cycle.
REQ-031 After a forced release, re-locking SHALL require b_lock to be sampled 0 at least once.
REQ-032 b_lock asserted while port A wins arbitration: no lock taken; port B SHALL be granted next (round-robin) and lock then.
REQ-033 Requests not granted SHALL NOT be queued; requesters hold their signals until granted.

Reset
REQ-034 Asserting rst_n low SHALL immediately force UNLOCKED, last-grant pointer = B (A wins the first tie), idle counter 0, rvalid both 0, core_halt 0, lock_timeout 0, and the no-grant memory outputs.
REQ-035 A read issued in the cycle before reset SHALL NOT produce rvalid after reset deasserts.

Verification
REQ-036 a_req and b_req both high after reset, both reads, 4 cycles -> grants A,B,A,B; rvalid one cycle after each grant.
REQ-037 Port B write addr 0x05 data 0x1234, then port A read 0x05 -> a_rvalid=1 with a_rdata=0x1234 one cycle after a_gnt.
REQ-038 b_req+b_lock granted, a_req held high 10 cycles -> a_gnt=0 and core_halt=1 throughout; b_lock low -> a_gnt=1 in the next cycle.
REQ-039 LOCK_TIMEOUT=4, lock then b_req=0 with b_lock held -> lock_timeout pulses on the 4th idle cycle, core_halt drops, no re-lock until b_lock toggles low.
REQ-040 rst_n pulsed low mid-cycle while LOCKED with a read in flight -> core_halt=0 and rvalid=0 immediately, with no rvalid after release.
